// File: rtl/la_pkg.sv
// Shared types and constants for the logic-analyser capture core.
package la_pkg;

   localparam int LA_TS_W = 16;

   typedef enum logic [2:0] {
      LA_IDLE = 3'd0,
      LA_PRE  = 3'd1,
      LA_WAIT = 3'd2,
      LA_POST = 3'd3,
      LA_DONE = 3'd4,
      LA_READ = 3'd5
   } la_state_t;

endpackage

// File: rtl/la_sample_ram.sv
// Simple dual-port sample buffer, DEPTH x DATA_W, registered read port.
// No reset on storage or read register so the tools can map it onto block RAM.
module la_sample_ram
   import la_pkg::*;
#(
   parameter int DATA_W = 41,
   parameter int DEPTH  = 1024,
   parameter int AW     = $clog2(DEPTH)
) (
   input  logic              clk_i,
   input  logic              wr_en_i,
   input  logic [AW-1:0]     wr_addr_i,
   input  logic [DATA_W-1:0] wr_data_i,
   input  logic              rd_en_i,
   input  logic [AW-1:0]     rd_addr_i,
   output logic [DATA_W-1:0] rd_data_o
);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [DATA_W-1:0] rdData_q;

   always_ff @(posedge clk_i) begin
      if (wr_en_i) begin
         mem[wr_addr_i] <= wr_data_i;
      end
   end

   // The read register only advances on rd_en_i, so it doubles as the readout hold stage.
   always_ff @(posedge clk_i) begin
      if (rd_en_i) begin
         rdData_q <= mem[rd_addr_i];
      end
   end

   assign rd_data_o = rdData_q;

endmodule

// File: rtl/la_capture_core.sv
// Logic-analyser capture core: circular pre-trigger buffer, masked level/edge trigger, streamed readout.
// Optional feature macro LA_TIMESTAMP_EN adds an arm-to-trigger cycle counter on trig_time_o.
module la_capture_core
   import la_pkg::*;
#(
   parameter  int DATA_W = 41,
   parameter  int DEPTH  = 1024,
   parameter  int TRIG_W = 4,
   localparam int AW     = $clog2(DEPTH)
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic [DATA_W-1:0]   data_i,
   input  logic [TRIG_W-1:0]   trig_i,
   input  logic [TRIG_W-1:0]   trig_mask_i,
   input  logic [TRIG_W-1:0]   trig_value_i,
   input  logic [TRIG_W-1:0]   trig_edge_i,
   input  logic [AW-1:0]       pre_trig_i,
   input  logic                arm_i,
   input  logic                rd_start_i,
   output logic [DATA_W-1:0]   rd_data_o,
   output logic                rd_valid_o,
   input  logic                rd_ready_i,
   output logic                rd_last_o,
   output logic [2:0]          state_o,
   output logic                triggered_o,
   output logic                done_o,
   output logic [LA_TS_W-1:0]  trig_time_o
);

   la_state_t         state_q;
   logic [AW-1:0]     wrPtr_q;
   logic [AW-1:0]     trigPtr_q;
   logic [AW-1:0]     pre_q;
   logic [AW-1:0]     cnt_q;
   logic [AW-1:0]     rdPtr_q;
   logic [AW:0]       rdLeft_q;
   logic              rdStarted_q;
   logic              rdValid_q;
   logic              rdLast_q;
   logic              triggered_q;
   logic              done_q;
   logic [TRIG_W-1:0] trig_q;

   logic [TRIG_W-1:0] lineOk;
   logic              trigHit;
   logic [AW-1:0]     postLen;
   logic              wrEn;
   logic              ramRdEn;
   logic [DATA_W-1:0] ramData;

   // A line passes if it is masked out, or matches its value and (in edge mode) was not already at it.
   assign lineOk  = ~trig_mask_i
                  | (~(trig_i ^ trig_value_i) & (~trig_edge_i | (trig_q ^ trig_value_i)));
   assign trigHit = &lineOk;

   // Samples after the trigger: DEPTH-1-pre, which in AW bits is simply ~pre.
   assign postLen = ~pre_q;

   assign wrEn = !arm_i && (state_q == LA_PRE || state_q == LA_WAIT || state_q == LA_POST);

   assign ramRdEn = !arm_i && (state_q == LA_READ) && rdStarted_q && (rdLeft_q != '0)
                  && (!rdValid_q || rd_ready_i);

   la_sample_ram #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .AW     (AW)
   ) u_ram (
      .clk_i     (clk_i),
      .wr_en_i   (wrEn),
      .wr_addr_i (wrPtr_q),
      .wr_data_i (data_i),
      .rd_en_i   (ramRdEn),
      .rd_addr_i (rdPtr_q),
      .rd_data_o (ramData)
   );

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q     <= LA_IDLE;
         wrPtr_q     <= '0;
         trigPtr_q   <= '0;
         pre_q       <= '0;
         cnt_q       <= '0;
         rdPtr_q     <= '0;
         rdLeft_q    <= '0;
         rdStarted_q <= 1'b0;
         rdValid_q   <= 1'b0;
         rdLast_q    <= 1'b0;
         triggered_q <= 1'b0;
         done_q      <= 1'b0;
         trig_q      <= '0;
      end else begin
         trig_q <= trig_i;
         if (arm_i) begin
            pre_q       <= pre_trig_i;
            wrPtr_q     <= '0;
            trigPtr_q   <= '0;
            cnt_q       <= '0;
            rdPtr_q     <= '0;
            rdLeft_q    <= '0;
            rdStarted_q <= 1'b0;
            rdValid_q   <= 1'b0;
            rdLast_q    <= 1'b0;
            triggered_q <= 1'b0;
            done_q      <= 1'b0;
            state_q     <= (pre_trig_i == '0) ? LA_WAIT : LA_PRE;
         end else begin
            case (state_q)
               LA_PRE: begin
                  wrPtr_q <= wrPtr_q + AW'(1);
                  cnt_q   <= cnt_q + AW'(1);
                  if (cnt_q == pre_q - AW'(1)) begin
                     state_q <= LA_WAIT;
                  end
               end
               LA_WAIT: begin
                  wrPtr_q <= wrPtr_q + AW'(1);
                  if (trigHit) begin
                     trigPtr_q   <= wrPtr_q;
                     triggered_q <= 1'b1;
                     cnt_q       <= '0;
                     if (postLen == '0) begin
                        state_q <= LA_DONE;
                        done_q  <= 1'b1;
                     end else begin
                        state_q <= LA_POST;
                     end
                  end
               end
               LA_POST: begin
                  wrPtr_q <= wrPtr_q + AW'(1);
                  cnt_q   <= cnt_q + AW'(1);
                  if (cnt_q == postLen - AW'(1)) begin
                     state_q <= LA_DONE;
                     done_q  <= 1'b1;
                  end
               end
               LA_DONE: begin
                  if (rd_start_i) begin
                     state_q     <= LA_READ;
                     rdPtr_q     <= trigPtr_q - pre_q;
                     rdLeft_q    <= (AW+1)'(DEPTH);
                     rdStarted_q <= 1'b0;
                  end
               end
               LA_READ: begin
                  // One idle cycle after entry gives the two-cycle start latency.
                  rdStarted_q <= 1'b1;
                  if (ramRdEn) begin
                     rdPtr_q   <= rdPtr_q + AW'(1);
                     rdLeft_q  <= rdLeft_q - (AW+1)'(1);
                     rdValid_q <= 1'b1;
                     rdLast_q  <= (rdLeft_q == (AW+1)'(1));
                  end else if (rd_ready_i) begin
                     rdValid_q <= 1'b0;
                     rdLast_q  <= 1'b0;
                  end
                  if (rdValid_q && rd_ready_i && rdLast_q) begin
                     state_q   <= LA_IDLE;
                     done_q    <= 1'b0;
                     rdValid_q <= 1'b0;
                     rdLast_q  <= 1'b0;
                  end
               end
               default: begin
               end
            endcase
         end
      end
   end

`ifdef LA_TIMESTAMP_EN
   logic [LA_TS_W-1:0] tsCnt_q;
   logic [LA_TS_W-1:0] tsNext;
   logic [LA_TS_W-1:0] trigTime_q;

   assign tsNext = (tsCnt_q == '1) ? tsCnt_q : tsCnt_q + LA_TS_W'(1);

   // The recorded time includes the trigger cycle itself, i.e. edges elapsed since the arm edge.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         tsCnt_q    <= '0;
         trigTime_q <= '0;
      end else if (arm_i) begin
         tsCnt_q    <= '0;
         trigTime_q <= '0;
      end else begin
         if (state_q == LA_PRE || state_q == LA_WAIT) begin
            tsCnt_q <= tsNext;
         end
         if (state_q == LA_WAIT && trigHit) begin
            trigTime_q <= tsNext;
         end
      end
   end

   assign trig_time_o = trigTime_q;
`else
   assign trig_time_o = '0;
`endif

   assign state_o     = state_q;
   assign rd_valid_o  = rdValid_q;
   assign rd_last_o   = rdLast_q;
   assign rd_data_o   = rdValid_q ? ramData : '0;
   assign triggered_o = triggered_q;
   assign done_o      = done_q;

endmodule

// File: doc/la_capture_core.md
# la_capture_core

Parametrised on-chip logic-analyser capture core: the configurable successor to the fixed 41-bit debug probe on the debug clock. Samples a DATA_W-bit probe bus into a circular buffer every cycle once armed, evaluates a masked level/edge trigger over TRIG_W trigger lines, and keeps a programmable pre-trigger window. It then streams the DEPTH-sample window, oldest first, over a valid/ready readout port to the debug host bridge.

## Interface
- DATA_W, 41, probe bus width (1..256)
- DEPTH, 1024, samples per capture; power of two, 16..65536
- TRIG_W, 4, trigger lines (1..32)
- AW, $clog2(DEPTH), address/count width (derived, not overridden)
- clk_i  in  1  sample clock (debug clock)
- rst_i  in  1  asynchronous reset, active-high
- data_i  in  DATA_W  probe bus
- trig_i  in  TRIG_W  trigger lines
- trig_mask_i  in  TRIG_W  1 = line participates
- trig_value_i  in  TRIG_W  required level per line
- trig_edge_i  in  TRIG_W  1 = line must transition into value; 0 = level match
- pre_trig_i  in  AW  samples kept before the trigger sample; latched at arm
- arm_i  in  1  single-cycle pulse: start/restart capture
- rd_start_i  in  1  single-cycle pulse: start readout (honoured only in DONE)
- rd_data_o  out  DATA_W  readout sample
- rd_valid_o  out  1  rd_data_o valid
- rd_ready_i  in  1  host accepts sample
- rd_last_o  out  1  marks the final (DEPTH-th) sample
- state_o  out  3  current state encoding
- triggered_o  out  1  trigger seen in this capture
- done_o  out  1  capture complete, buffer readable
- trig_time_o  out  16  cycles from arm to trigger (LA_TIMESTAMP_EN only)

## Operation
- States: IDLE(0), PRE(1), WAIT(2), POST(3), DONE(4), READ(5).
- Trigger condition per cycle: AND over bits k with mask[k]=1 of (trig_i[k]==value[k]) && (!edge[k] || trig_q[k]!=value[k]); trig_q is trig_i registered. All-zero mask gives an always-true condition (forced trigger).
- arm_i in any state: latches pre_trig_i, clears pointers, triggered_o and done_o; enters PRE. arm_i during READ aborts the readout (rd_valid_o drops next cycle).
- PRE: writes data_i at wr_ptr, increments; after pre_trig_i writes goes to WAIT. With pre_trig_i=0, skips straight to WAIT on the arm cycle +1. Trigger conditions during PRE are ignored.
- WAIT: writes every cycle, wr_ptr wraps mod DEPTH. The first true condition writes that sample as the trigger sample, stores trig_ptr, sets triggered_o, and enters POST.
- POST: writes DEPTH-1-pre samples after the trigger sample, then DONE; done_o=1. If DEPTH-1-pre=0, enters DONE directly.
- Window start address = trig_ptr - pre (mod DEPTH).
- READ: after rd_start_i, streams DEPTH samples from the window start, oldest first, address wrapping. rd_data_o and rd_valid_o are held stable while rd_valid_o && !rd_ready_i. rd_last_o accompanies the final sample. After that transfer the block returns to IDLE; done_o clears.
- rd_start_i outside DONE, and arm_i coinciding with rd_start_i: arm wins; rd_start_i is ignored.

## Timing
- Reset values: state IDLE; rd_valid_o, rd_last_o, triggered_o, done_o = 0; rd_data_o = 0; trig_time_o = 0; pointers 0.
- Reset mid-capture or mid-readout: immediate return to IDLE; buffer contents undefined.
- Sample written in cycle t is data_i at edge t. Trigger sample = data_i in the cycle the condition is true.
- triggered_o rises 1 cycle after the trigger edge. done_o rises 1 cycle after the final POST write.
- Readout: synchronous RAM with 1-cycle latency. First rd_valid_o 2 cycles after rd_start_i. Sustains 1 sample/cycle with rd_ready_i held high.

## Configuration
- LA_TIMESTAMP_EN defined: a 16-bit saturating counter clears on arm and counts in PRE/WAIT. It is copied to trig_time_o on trigger and held until the next arm or reset.
- LA_TIMESTAMP_EN not defined: the counter is absent and trig_time_o is tied to 0.

## Structure
- Package la_pkg: state enum la_state_t with the encodings above; constant LA_TS_W=16.
- Sub-module la_sample_ram: simple dual-port, DEPTH x DATA_W, 1-cycle registered read, infers block RAM. All control lives in la_capture_core.

## Test plan
- DEPTH=16, pre=4, data_i=cycle count, level trigger on trig_i[0]=1 asserted at cycle 20 after arm -> readout yields 16 samples with value 16..31, trigger sample 20 in position 4, rd_last_o on sample 16.
- Edge trigger on trig_i[1] rising while held high at arm -> no trigger until a 0->1 transition. Level mode with the same stimulus -> trigger on the first WAIT cycle.
- Mask=0, pre=0 -> trigger on the first WAIT sample; done_o after 16 writes; the window begins at the trigger sample.
- rd_ready_i toggled 1,0,0,1... -> rd_data_o held stable during stalls; exactly 16 handshakes; return to IDLE.
- arm_i pulsed mid-POST and again mid-READ -> capture restarts and triggered_o/done_o clear. rst_i mid-WAIT -> all outputs take their reset values asynchronously.
- With LA_TIMESTAMP_EN, pre=3, trigger 10 cycles after arm -> trig_time_o=10 (±0 by definition: counter value at the trigger cycle).
